// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-unit result FIFOs feeding one registered
// broadcast port, granted by fixed priority or round-robin.
module cdb_arbiter #(
  parameter int N_FU   = 2,
  parameter int DATA_W = 4,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2,
  parameter int RR     = 1,
  localparam int SRC_W = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_FU-1:0]        fu_done,
  input  logic [N_FU*TAG_W-1:0]  fu_tag,
  input  logic [N_FU*DATA_W-1:0] fu_result,
  output logic [N_FU-1:0]        fu_stall,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [SRC_W-1:0]       cdb_src,
  output logic [N_FU-1:0]        overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [TAG_W-1:0]  q_tag  [N_FU][DEPTH];
  logic [DATA_W-1:0] q_data [N_FU][DEPTH];
  logic [CNT_W-1:0]  count  [N_FU];
  logic [PTR_W-1:0]  rd_ptr [N_FU];
  logic [PTR_W-1:0]  wr_ptr [N_FU];
  logic [SRC_W-1:0]  last_grant;

  logic [N_FU-1:0]   eligible;
  logic [N_FU-1:0]   grant;
  logic [N_FU-1:0]   push;
  logic [N_FU-1:0]   pop;
  logic              grant_any;
  int unsigned       grant_idx;
  int unsigned       lg;
  int unsigned       rank;
  int unsigned       best;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    fu_stall = '0;
    eligible = '0;
    for (int unsigned i = 0; i < N_FU; i++) begin
      fu_stall[i] = (count[i] == FULL);
      eligible[i] = (count[i] != '0) || fu_done[i];
    end
  end

  // Rank 0 wins: in round-robin mode a channel's rank is its distance above last_grant.
  always_comb begin
    lg        = 32'(last_grant);
    rank      = 0;
    best      = N_FU;
    grant_any = 1'b0;
    grant_idx = 0;
    for (int unsigned i = 0; i < N_FU; i++) begin
      rank = (RR != 0) ? (i + N_FU - 1 - lg) % N_FU : i;
      if (eligible[i] && rank < best) begin
        best      = rank;
        grant_idx = i;
        grant_any = 1'b1;
      end
    end
  end

  // A granted empty channel consumes its input directly instead of queueing it.
  always_comb begin
    grant    = '0;
    push     = '0;
    pop      = '0;
    sel_tag  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_FU; i++) begin
      grant[i] = grant_any && (grant_idx == i);
      pop[i]   = grant[i] && (count[i] != '0);
      push[i]  = fu_done[i] && !fu_stall[i] && !(grant[i] && count[i] == '0);
      if (grant[i]) begin
        sel_tag  = pop[i] ? q_tag[i][rd_ptr[i]]  : fu_tag[i*TAG_W +: TAG_W];
        sel_data = pop[i] ? q_data[i][rd_ptr[i]] : fu_result[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_FU; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      last_grant <= SRC_W'(N_FU - 1);
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      cdb_src    <= '0;
      overflow   <= '0;
    end else begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_tag    <= sel_tag;
        cdb_data   <= sel_data;
        cdb_src    <= SRC_W'(grant_idx);
        last_grant <= SRC_W'(grant_idx);
      end
      for (int unsigned i = 0; i < N_FU; i++) begin
        if (push[i]) begin
          q_tag[i][wr_ptr[i]]  <= fu_tag[i*TAG_W +: TAG_W];
          q_data[i][wr_ptr[i]] <= fu_result[i*DATA_W +: DATA_W];
          wr_ptr[i]            <= ptr_inc(wr_ptr[i]);
        end
        if (pop[i]) begin
          rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        end
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (pop[i] && !push[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
        if (fu_done[i] && fu_stall[i]) begin
          overflow[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: four parameterisations on one stimulus bus, directed
// vector table, hand sequences, and random traffic against a queue model.
module tb_cdb_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] done = '0;
  logic [4:0] tagv [4];
  logic [7:0] datv [4];

  always #5 clock = ~clock;

  logic [1:0] c0_stall, c0_ovf, c1_stall, c1_ovf, c3_stall, c3_ovf;
  logic       c0_valid, c1_valid, c2_valid, c3_valid;
  logic [3:0] c0_tag, c0_data, c1_tag, c1_data, c3_tag, c3_data;
  logic [0:0] c0_src, c1_src, c3_src;
  logic [3:0] c2_stall, c2_ovf;
  logic [4:0] c2_tag;
  logic [7:0] c2_data;
  logic [1:0] c2_src;

  cdb_arbiter #(.N_FU(2), .DATA_W(4), .TAG_W(4), .DEPTH(2), .RR(1)) u_def (
    .clock(clock), .reset_n(reset_n), .fu_done(done[1:0]),
    .fu_tag({tagv[1][3:0], tagv[0][3:0]}), .fu_result({datv[1][3:0], datv[0][3:0]}),
    .fu_stall(c0_stall), .cdb_valid(c0_valid), .cdb_tag(c0_tag), .cdb_data(c0_data),
    .cdb_src(c0_src), .overflow(c0_ovf));

  cdb_arbiter #(.N_FU(2), .DATA_W(4), .TAG_W(4), .DEPTH(2), .RR(0)) u_fix (
    .clock(clock), .reset_n(reset_n), .fu_done(done[1:0]),
    .fu_tag({tagv[1][3:0], tagv[0][3:0]}), .fu_result({datv[1][3:0], datv[0][3:0]}),
    .fu_stall(c1_stall), .cdb_valid(c1_valid), .cdb_tag(c1_tag), .cdb_data(c1_data),
    .cdb_src(c1_src), .overflow(c1_ovf));

  cdb_arbiter #(.N_FU(4), .DATA_W(8), .TAG_W(5), .DEPTH(2), .RR(1)) u_n4 (
    .clock(clock), .reset_n(reset_n), .fu_done(done),
    .fu_tag({tagv[3], tagv[2], tagv[1], tagv[0]}), .fu_result({datv[3], datv[2], datv[1], datv[0]}),
    .fu_stall(c2_stall), .cdb_valid(c2_valid), .cdb_tag(c2_tag), .cdb_data(c2_data),
    .cdb_src(c2_src), .overflow(c2_ovf));

  cdb_arbiter #(.N_FU(2), .DATA_W(4), .TAG_W(4), .DEPTH(3), .RR(1)) u_d3 (
    .clock(clock), .reset_n(reset_n), .fu_done(done[1:0]),
    .fu_tag({tagv[1][3:0], tagv[0][3:0]}), .fu_result({datv[1][3:0], datv[0][3:0]}),
    .fu_stall(c3_stall), .cdb_valid(c3_valid), .cdb_tag(c3_tag), .cdb_data(c3_data),
    .cdb_src(c3_src), .overflow(c3_ovf));

  int         cfg = 0;
  logic [3:0] o_stall, o_ovf;
  logic       o_valid;
  logic [4:0] o_tag;
  logic [7:0] o_data;
  logic [1:0] o_src;

  always_comb begin
    o_stall = '0; o_ovf = '0; o_valid = 1'b0; o_tag = '0; o_data = '0; o_src = '0;
    case (cfg)
      0: begin
        o_stall = {2'b0, c0_stall}; o_ovf = {2'b0, c0_ovf}; o_valid = c0_valid;
        o_tag = {1'b0, c0_tag}; o_data = {4'b0, c0_data}; o_src = {1'b0, c0_src};
      end
      1: begin
        o_stall = {2'b0, c1_stall}; o_ovf = {2'b0, c1_ovf}; o_valid = c1_valid;
        o_tag = {1'b0, c1_tag}; o_data = {4'b0, c1_data}; o_src = {1'b0, c1_src};
      end
      2: begin
        o_stall = c2_stall; o_ovf = c2_ovf; o_valid = c2_valid;
        o_tag = c2_tag; o_data = c2_data; o_src = c2_src;
      end
      default: begin
        o_stall = {2'b0, c3_stall}; o_ovf = {2'b0, c3_ovf}; o_valid = c3_valid;
        o_tag = {1'b0, c3_tag}; o_data = {4'b0, c3_data}; o_src = {1'b0, c3_src};
      end
    endcase
  end

  int nchk = 0;
  int nerr = 0;
  int step_id = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s step %0d cfg %0d: got %0h, expected %0h", nm, step_id, cfg, act, exp);
    end
  endtask

  task automatic chk_all(input int ev, input int et, input int ed, input int es,
                         input int est, input int eov);
    chk("cdb_valid", 32'(o_valid), ev);
    chk("cdb_tag",   32'(o_tag),   et);
    chk("cdb_data",  32'(o_data),  ed);
    chk("cdb_src",   32'(o_src),   es);
    chk("fu_stall",  32'(o_stall), est);
    chk("overflow",  32'(o_ovf),   eov);
  endtask

  // Reference model: per-channel arrays used as queues, arbitration by search.
  int          mn, mdep, mrr, mtw, mdw;
  logic [12:0] mq [4][8];
  int          mc [4];
  int          mlg, ms;
  logic        mv;
  logic [4:0]  mt;
  logic [7:0]  md;
  logic [3:0]  mov;

  task automatic set_cfg(input int c);
    cfg = c;
    mn   = (c == 2) ? 4 : 2;
    mdep = (c == 3) ? 3 : 2;
    mrr  = (c == 1) ? 0 : 1;
    mtw  = (c == 2) ? 5 : 4;
    mdw  = (c == 2) ? 8 : 4;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mc[i] = 0;
    mlg = mn - 1; ms = 0; mv = 1'b0; mt = '0; md = '0; mov = '0;
  endfunction

  function automatic void model_step();
    int         g;
    int         c;
    bit         byp;
    bit         full [4];
    logic [4:0] tm;
    logic [7:0] dm;
    tm = (mtw == 5) ? 5'h1f : 5'h0f;
    dm = (mdw == 8) ? 8'hff : 8'h0f;
    g = -1;
    byp = 1'b0;
    for (int i = 0; i < 4; i++) full[i] = (i < mn) && (mc[i] == mdep);
    for (int k = 0; k < mn; k++) begin
      c = (mrr != 0) ? (mlg + 1 + k) % mn : k;
      if (g < 0 && (mc[2'(c)] > 0 || done[2'(c)])) g = c;
    end
    mv = (g >= 0);
    if (g >= 0) begin
      ms = g;
      mlg = g;
      if (mc[2'(g)] > 0) begin
        mt = mq[2'(g)][0][12:8];
        md = mq[2'(g)][0][7:0];
        for (int j = 0; j < 7; j++) mq[2'(g)][j] = mq[2'(g)][j+1];
        mc[2'(g)]--;
      end else begin
        mt = tagv[2'(g)] & tm;
        md = datv[2'(g)] & dm;
        byp = 1'b1;
      end
    end
    for (int i = 0; i < mn; i++) begin
      if (done[i]) begin
        if (full[i]) mov[i] = 1'b1;
        else if (!(byp && i == g)) begin
          mq[i][mc[i]] = {tagv[i] & tm, datv[i] & dm};
          mc[i]++;
        end
      end
    end
  endfunction

  task automatic chk_model();
    logic [3:0] st;
    st = '0;
    for (int i = 0; i < mn; i++) st[i] = (mc[i] == mdep);
    chk("cdb_valid", 32'(o_valid), 32'(mv));
    chk("cdb_tag",   32'(o_tag),   32'(mt));
    chk("cdb_data",  32'(o_data),  32'(md));
    chk("cdb_src",   32'(o_src),   ms);
    chk("fu_stall",  32'(o_stall), 32'(st));
    chk("overflow",  32'(o_ovf),   32'(mov));
  endtask

  task automatic edge_step(input bit use_model);
    if (use_model) begin
      if (!reset_n) model_reset();
      else model_step();
    end
    @(posedge clock);
    #1;
    step_id++;
  endtask

  task automatic drive(input int rst, input int dn, input int t0, input int d0,
                       input int t1, input int d1);
    reset_n = (rst == 0);
    done = 4'(dn);
    tagv[0] = 5'(t0); datv[0] = 8'(d0);
    tagv[1] = 5'(t1); datv[1] = 8'(d1);
    tagv[2] = '0; datv[2] = '0;
    tagv[3] = '0; datv[3] = '0;
  endtask

  typedef struct {
    int cfg, rst, dn, t0, d0, t1, d1;
    int ev, et, ed, es, st, ov;
  } vec_t;

  function automatic vec_t mk(input int c, input int r, input int dn, input int t0, input int d0,
                              input int t1, input int d1, input int ev, input int et,
                              input int ed, input int es, input int st, input int ov);
    vec_t v;
    v.cfg = c; v.rst = r; v.dn = dn; v.t0 = t0; v.d0 = d0; v.t1 = t1; v.d1 = d1;
    v.ev = ev; v.et = et; v.ed = ed; v.es = es; v.st = st; v.ov = ov;
    return v;
  endfunction

  vec_t vt [$];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d", nchk);
    $fatal(1, "time limit");
  end

  initial begin
    int p;
    for (int i = 0; i < 4; i++) begin tagv[i] = '0; datv[i] = '0; end

    // cfg0 single result, then simultaneous pair, then RR alternation with ch1 filling
    vt.push_back(mk(0, 1, 3, 7, 7, 7, 7,   0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 3, 5, 0, 0,   1, 3, 5, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 3, 5, 0, 0, 0));
    vt.push_back(mk(0, 1, 3, 7, 7, 7, 7,   0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 3, 1, 2, 2, 6,   1, 1, 2, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 2, 6, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 2, 6, 1, 0, 0));
    vt.push_back(mk(0, 1, 3, 7, 7, 7, 7,   0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 3, 1, 4, 8, 12,  1, 1, 4, 0, 0, 0));
    vt.push_back(mk(0, 0, 3, 2, 5, 9, 13,  1, 8, 12, 1, 0, 0));
    vt.push_back(mk(0, 0, 3, 3, 6, 10, 14, 1, 2, 5, 0, 2, 0));
    vt.push_back(mk(0, 0, 3, 4, 7, 11, 15, 1, 9, 13, 1, 1, 2));
    // cfg1 fixed priority: ch0 always wins, ch1 fills, third strobe dropped
    vt.push_back(mk(1, 1, 3, 7, 7, 7, 7,   0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 3, 1, 4, 8, 12,  1, 1, 4, 0, 0, 0));
    vt.push_back(mk(1, 0, 3, 2, 5, 9, 13,  1, 2, 5, 0, 2, 0));
    vt.push_back(mk(1, 0, 3, 3, 6, 10, 14, 1, 3, 6, 0, 2, 2));
    vt.push_back(mk(1, 0, 1, 4, 7, 0, 0,   1, 4, 7, 0, 2, 2));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0,   1, 8, 12, 1, 0, 2));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0,   1, 9, 13, 1, 0, 2));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0, 9, 13, 1, 0, 2));

    foreach (vt[r]) begin
      cfg = vt[r].cfg;
      drive(vt[r].rst, vt[r].dn, vt[r].t0, vt[r].d0, vt[r].t1, vt[r].d1);
      edge_step(0);
      chk_all(vt[r].ev, vt[r].et, vt[r].ed, vt[r].es, vt[r].st, vt[r].ov);
    end

    // Four channels, two bursts: channel 0 leads both times
    cfg = 2;
    drive(1, 0, 0, 0, 0, 0);
    edge_step(0);
    chk_all(0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 2; b++) begin
      reset_n = 1'b1;
      done = 4'hf;
      for (int i = 0; i < 4; i++) begin
        tagv[i] = 5'(10 + 10 * b + i);
        datv[i] = 8'(8'ha0 + 16 * b + i);
      end
      for (int k = 0; k < 4; k++) begin
        edge_step(0);
        done = '0;
        chk_all(1, 10 + 10 * b + k, 'ha0 + 16 * b + k, k, 0, 0);
      end
      edge_step(0);
      chk_all(0, 13 + 10 * b, 'ha3 + 16 * b, 3, 0, 0);
    end

    // Seven back-to-back results on ch1 with DEPTH=3
    cfg = 3;
    drive(1, 0, 0, 0, 0, 0);
    edge_step(0);
    chk_all(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      drive(0, 2, 0, 0, k + 1, 15 - k);
      edge_step(0);
      chk_all(1, k + 1, 15 - k, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    edge_step(0);
    chk_all(0, 7, 9, 1, 0, 0);

    // Reset while ch1 still holds an entry and overflow is set
    cfg = 1;
    drive(1, 0, 0, 0, 0, 0);
    edge_step(0);
    drive(0, 3, 1, 1, 5, 5);
    edge_step(0);
    drive(0, 3, 2, 2, 6, 6);
    edge_step(0);
    drive(0, 2, 0, 0, 7, 7);
    edge_step(0);
    chk_all(1, 5, 5, 1, 0, 2);
    drive(1, 3, 3, 3, 8, 8);
    edge_step(0);
    chk_all(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      edge_step(0);
      chk_all(0, 0, 0, 0, 0, 0);
    end

    // Random traffic on every configuration, light then heavy, with sporadic resets
    for (int c = 0; c < 4; c++) begin
      set_cfg(c);
      drive(1, 0, 0, 0, 0, 0);
      edge_step(1);
      chk_model();
      for (int n = 0; n < 300; n++) begin
        p = (n < 150) ? 40 : 75;
        reset_n = ($urandom_range(0, 59) != 0);
        for (int i = 0; i < 4; i++) begin
          done[i] = ($urandom_range(0, 99) < p);
          tagv[i] = 5'($urandom);
          datv[i] = 8'($urandom);
        end
        edge_step(1);
        chk_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
